// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters and resolve statistics
module branch_predictor #(
    parameter int DATA_WIDTH = 64,
    parameter int ENTRIES    = 64,
    parameter int TAG_WIDTH  = 12,
    parameter int CTR_WIDTH  = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pred_taken_o,
    output logic [DATA_WIDTH-1:0] pred_pc_o,
    input  logic                  upd_valid_i,
    input  logic [DATA_WIDTH-1:0] upd_pc_i,
    input  logic                  upd_taken_i,
    input  logic                  upd_uncond_i,
    input  logic [DATA_WIDTH-1:0] upd_target_i,
    input  logic                  upd_mispred_i,
    input  logic                  invalidate_i,
    output logic [STAT_WIDTH-1:0] resolved_cnt_o,
    output logic [STAT_WIDTH-1:0] mispred_cnt_o
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + 2 + TAG_WIDTH - 1;

    // Counter encodings: MSB is the predicted direction.
    localparam logic [CTR_WIDTH-1:0] CTR_MAX = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_MIN = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0] CTR_WT  = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_WNT = CTR_WT - CTR_WIDTH'(1);

    // Table state
    logic [ENTRIES-1:0]    valid_q;
    logic [TAG_WIDTH-1:0]  tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_WIDTH-1:0]  ctr_q    [ENTRIES];

    // Lookup side
    logic [IDX_W-1:0]     lk_idx;
    logic [TAG_WIDTH-1:0] lk_tag;
    logic                 lk_hit;

    // Update side
    logic [IDX_W-1:0]     up_idx;
    logic [TAG_WIDTH-1:0] up_tag;
    logic                 up_hit;
    logic                 up_taken;
    logic                 up_write;
    logic [CTR_WIDTH-1:0] up_ctr;

    logic [STAT_WIDTH-1:0] resolved_q;
    logic [STAT_WIDTH-1:0] mispred_q;

    assign lk_idx = pc_i[TAG_LO-1:2];
    assign lk_tag = pc_i[TAG_HI:TAG_LO];
    assign up_idx = upd_pc_i[TAG_LO-1:2];
    assign up_tag = upd_pc_i[TAG_HI:TAG_LO];

    // Fetch-side prediction reads pre-edge table state only; there is no update bypass.
    always_comb begin
        lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o = lk_hit && ctr_q[lk_idx][CTR_WIDTH-1];
        pred_pc_o    = pred_taken_o ? target_q[lk_idx] : (pc_i + DATA_WIDTH'(4));
    end

    // Next counter value and write decision for the resolving instruction.
    always_comb begin
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_taken = upd_taken_i || upd_uncond_i;
        up_ctr   = ctr_q[up_idx];
        if (upd_uncond_i) begin
            up_ctr = CTR_MAX;
        end else if (up_hit) begin
            if (upd_taken_i) begin
                up_ctr = (ctr_q[up_idx] == CTR_MAX) ? CTR_MAX : ctr_q[up_idx] + CTR_WIDTH'(1);
            end else begin
                up_ctr = (ctr_q[up_idx] == CTR_MIN) ? CTR_MIN : ctr_q[up_idx] - CTR_WIDTH'(1);
            end
        end else begin
            up_ctr = CTR_WT;
        end
        // A not-taken miss leaves the table alone; invalidate drops the write.
        up_write = upd_valid_i && !invalidate_i && (up_hit || up_taken);
    end

    // Table write: allocate/train on resolve, clear valids on invalidate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (invalidate_i) begin
            valid_q <= '0;
        end else if (up_write) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            ctr_q[up_idx]   <= up_ctr;
            if (up_taken) begin
                target_q[up_idx] <= upd_target_i;
            end
        end
    end

    // Statistics keep counting through invalidate and wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resolved_q <= '0;
            mispred_q  <= '0;
        end else if (upd_valid_i) begin
            resolved_q <= resolved_q + STAT_WIDTH'(1);
            if (upd_mispred_i) begin
                mispred_q <= mispred_q + STAT_WIDTH'(1);
            end
        end
    end

    assign resolved_cnt_o = resolved_q;
    assign mispred_cnt_o  = mispred_q;

    // PC bits outside index/tag do not participate in the update path.
    generate
        if (TAG_HI + 1 < DATA_WIDTH) begin : g_unused_hi
            logic unused_upd_pc;
            assign unused_upd_pc = ^{upd_pc_i[1:0], upd_pc_i[DATA_WIDTH-1:TAG_HI+1]};
        end else begin : g_unused_lo
            logic unused_upd_pc;
            assign unused_upd_pc = ^upd_pc_i[1:0];
        end
    endgenerate

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor that replaces the fixed PC+4 next-PC guess in the 5-stage RV64I pipeline.
- IF looks up the current PC combinationally and receives a predicted next PC.
- EX, the stage that resolves branches, writes outcomes back into a direct-mapped BTB that holds an n-bit saturating counter per entry.
- Also keeps resolved-branch and misprediction counters for the simulation harness.

Parameters:
- DATA_WIDTH, 64, PC/target width.
- ENTRIES, 64, BTB/BHT entry count; power of two, >= 2.
- TAG_WIDTH, 12, stored tag bits per entry; requires IDX_W+2+TAG_WIDTH <= DATA_WIDTH.
- CTR_WIDTH, 2, saturating counter width; >= 1.
- STAT_WIDTH, 32, width of the statistics counters.
- Derived: IDX_W = log2(ENTRIES).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- pc_i  in  DATA_WIDTH  IF-stage fetch PC
- pred_taken_o  out  1  prediction for pc_i
- pred_pc_o  out  DATA_WIDTH  predicted next PC
- upd_valid_i  in  1  EX resolves a control-transfer instruction this cycle
- upd_pc_i  in  DATA_WIDTH  PC of the resolved instruction
- upd_taken_i  in  1  actual direction
- upd_uncond_i  in  1  JAL/JALR (always taken)
- upd_target_i  in  DATA_WIDTH  actual taken target
- upd_mispred_i  in  1  pipeline flushed for this instruction
- invalidate_i  in  1  clear all entries (FENCE.I / context change)
- resolved_cnt_o  out  STAT_WIDTH  count of updates accepted
- mispred_cnt_o  out  STAT_WIDTH  count of mispredictions

Behaviour:
- Entry state: valid, tag, target[DATA_WIDTH], ctr[CTR_WIDTH].
- Address split: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+2+TAG_WIDTH-1:IDX_W+2]; pc[1:0] ignored.
- Lookup is purely combinational from pc_i, with zero cycle latency.
  - hit = valid[idx] && tag match.
  - pred_taken_o = hit && ctr[idx] MSB.
  - pred_pc_o = pred_taken_o ? target[idx] : pc_i + 4, with modulo-2^DATA_WIDTH wrap.
- Update is registered and takes effect at the rising edge where upd_valid_i=1. Uncond is treated as taken.
  - Hit, taken: ctr saturating increment (stays at all-ones); target <= upd_target_i.
  - Hit, not-taken: ctr saturating decrement (stays at 0); target unchanged.
  - Miss, taken: allocate by overwriting the entry. valid=1, new tag, target, ctr = weakly-taken (MSB=1, rest 0).
  - Miss, not-taken: no change.
  - upd_uncond_i=1: ctr forced to all-ones, regardless of hit.
- Same-cycle lookup and update on the same index: lookup sees pre-edge state (no bypass). The new state is visible from the next cycle.
- invalidate_i=1: all valid bits cleared at the edge. A concurrent table update is dropped; invalidate wins. Counters/targets are not cleared.
- Statistics:
  - resolved_cnt_o increments on every upd_valid_i edge.
  - mispred_cnt_o increments when upd_valid_i && upd_mispred_i.
  - upd_mispred_i without upd_valid_i is ignored.
  - Both counters wrap modulo 2^STAT_WIDTH and still count during invalidate_i.
- Reset (rst_ni=0, async, any time including mid-update):
  - All valid=0, ctr = weakly-not-taken (MSB=0, lower bits all ones; 0 when CTR_WIDTH=1), targets 0, both stat counters 0.
  - pred_taken_o=0, pred_pc_o=pc_i+4 immediately.
  - Updates are ignored while reset is held. Normal operation resumes on the first edge after deassertion.

Test Plan:
- Reset, pc_i=0x1000 -> pred_taken_o=0, pred_pc_o=0x1004; resolved_cnt_o=mispred_cnt_o=0.
- Update pc=0x1000 taken target 0x2000 mispred=1, then lookup 0x1000 -> taken, pred_pc_o=0x2000; resolved=1, mispred=1.
- Two not-taken updates at 0x1000 after allocation -> ctr 2→1→0, lookup gives 0x1004. Four taken updates -> ctr saturates at 3, with no wrap to 0.
- Alias: allocate 0x1000, then taken update at 0x1000+4*ENTRIES (same idx, different tag), target 0x3000 -> 0x1000 misses (pred 0x1004); alias predicts 0x3000.
- JAL update pc=0x40 target 0x80 uncond=1 -> ctr=3, predicts 0x80. invalidate_i together with an update at 0x44 -> both lookups miss; resolved_cnt increments.
- Assert rst_ni low asynchronously mid-cycle with upd_valid_i=1 -> outputs return to reset values before the next edge, and the entry is not written.
- pc_i=0xFFFF_FFFF_FFFF_FFFC on a miss -> pred_pc_o=0.
